// File: rtl/mem_responder_if.sv
// Request/response bus between the MiniSRC datapath and the memory responder,
// plus the two external I/O port pins.
interface mem_responder_if;
    logic        iReq;
    logic        iWrite;
    logic [31:0] iAddr;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        oReady;
    logic        oErr;
    logic        oBusy;
    logic [31:0] iInPort;
    logic [31:0] oOutPort;

    // Datapath side: issues requests, consumes responses.
    modport master (
        output iReq, iWrite, iAddr, iData, iInPort,
        input  oData, oReady, oErr, oBusy, oOutPort
    );

    // Responder side.
    modport slave (
        input  iReq, iWrite, iAddr, iData, iInPort,
        output oData, oReady, oErr, oBusy, oOutPort
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM with configurable wait states and two
// memory-mapped I/O registers. Each request ends with a one-cycle oReady pulse.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] IN_ADDR     = 32'hFFFF_FFF0,
    parameter logic [31:0] OUT_ADDR    = 32'hFFFF_FFF1
) (
    input  logic             iClk,
    input  logic             iRst,
    mem_responder_if.slave   bus
);

    localparam int unsigned Depth    = 2 ** ADDR_BITS;
    localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    typedef enum logic [1:0] {DecIn, DecOut, DecRam, DecNone} dec_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_addr, r_wdata;
    logic        r_write;
    logic [31:0] r_data, r_out, r_in;
    logic [31:0] r_mem [Depth];

    logic [31:0] w_acc_addr;
    logic        w_acc_write;
    logic        w_enter_resp;
    dec_e        w_acc_dec, w_resp_dec;
    logic        w_do_write;

    function automatic dec_e decode(input logic [31:0] a);
        if (a == IN_ADDR)              return DecIn;
        else if (a == OUT_ADDR)        return DecOut;
        else if ((a >> ADDR_BITS) == 0) return DecRam;
        else                           return DecNone;
    endfunction

    // Access fields: live bus values when entering RESP straight from IDLE, latched otherwise.
    always_comb begin
        w_acc_addr   = (r_state == StIdle) ? bus.iAddr  : r_addr;
        w_acc_write  = (r_state == StIdle) ? bus.iWrite : r_write;
        w_acc_dec    = decode(w_acc_addr);
        w_resp_dec   = decode(r_addr);
        w_enter_resp = (w_state_next == StResp);
        w_do_write   = (r_state == StResp) && r_write;
    end

    // Next-state logic and wait-state counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.iReq) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = StWait;
                        w_cnt_next   = WaitInit;
                    end else begin
                        w_state_next = StResp;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) w_state_next = StResp;
                else               w_cnt_next   = r_cnt - 4'd1;
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State, request latch, I/O registers and read data.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_write <= 1'b0;
            r_in    <= 32'd0;
            r_data  <= 32'd0;
            r_out   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_in    <= bus.iInPort;
            if (r_state == StIdle && bus.iReq) begin
                r_addr  <= bus.iAddr;
                r_wdata <= bus.iData;
                r_write <= bus.iWrite;
            end
            // Read data is captured on the edge into RESP so it is valid with oReady.
            // The in-port value loaded here is the sample r_in holds during RESP.
            if (w_enter_resp && !w_acc_write) begin
                unique case (w_acc_dec)
                    DecIn:   r_data <= bus.iInPort;
                    DecOut:  r_data <= r_out;
                    DecRam:  r_data <= r_mem[w_acc_addr[ADDR_BITS-1:0]];
                    default: r_data <= 32'd0;
                endcase
            end
            if (w_do_write && w_resp_dec == DecOut) r_out <= r_wdata;
        end
    end

    // RAM write at the end of RESP; a reset in that cycle discards it.
    always_ff @(posedge iClk) begin
        if (!iRst && w_do_write && w_resp_dec == DecRam) begin
            r_mem[r_addr[ADDR_BITS-1:0]] <= r_wdata;
        end
    end

    // Response outputs.
    always_comb begin
        bus.oReady   = (r_state == StResp);
        bus.oErr     = (r_state == StResp) && (w_resp_dec == DecNone);
        bus.oBusy    = (r_state != StIdle);
        bus.oData    = r_data;
        bus.oOutPort = r_out;
    end

endmodule
